// File: rtl/ifu_prefetch_axil.sv
// ----------------------------------------------------------------------------
// ifu_prefetch_axil
//
// Instruction fetch unit with a DEPTH-entry prefetch buffer. Sequential
// instruction words are fetched over an AXI-Lite read channel, one request
// outstanding at a time. The buffer head is presented to the decoder with a
// valid/ready handshake. A redirect flushes the buffer and restarts fetching
// at a new address; a response belonging to a request issued before the
// redirect is consumed and dropped. A non-OKAY response is delivered as a
// faulting entry and stops further fetching until the next redirect.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect_valid    flush buffer and restart fetch at redirect_pc
//   redirect_pc       new fetch address (bits [1:0] ignored)
//   inst, inst_pc     head-of-buffer instruction word and its address
//   inst_fault        head entry came from a non-OKAY response
//   inst_valid        buffer non-empty
//   idu_ready         decoder takes the head entry this cycle
//   araddr, arvalid,
//   arready           AXI-Lite read address channel
//   rdata, rresp,
//   rvalid, rready    AXI-Lite read data channel
// ----------------------------------------------------------------------------
module ifu_prefetch_axil #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_fault,
   output logic            inst_valid,
   input  logic            idu_ready,
   output logic [XLEN-1:0] araddr,
   output logic            arvalid,
   input  logic            arready,
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      rresp,
   input  logic            rvalid,
   output logic            rready
);

   localparam int              PTR_W      = $clog2(DEPTH);
   localparam int              CNT_W      = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   typedef enum logic [1:0] {
      IDLE,
      SEND_ADDR,
      WAIT_DATA,
      DRAIN
   } state_t;

   state_t            state, state_d;
   logic [XLEN-1:0]   fetch_pc, fetch_pc_d;
   logic [XLEN-1:0]   araddr_d;
   logic              arvalid_d, rready_d;
   logic              halted, halted_d;
   // Set when a redirect lands while the address phase is still pending, so
   // the eventual response is routed to DRAIN instead of the buffer.
   logic              flush_pend, flush_pend_d;
   logic              push, pop;

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;

   logic [XLEN-1:0]   buf_inst  [DEPTH];
   logic [XLEN-1:0]   buf_pc    [DEPTH];
   logic              buf_fault [DEPTH];

   assign inst_valid = (count != '0);
   assign pop        = inst_valid && idu_ready;
   assign inst       = inst_valid ? buf_inst[rd_ptr]  : '0;
   assign inst_pc    = inst_valid ? buf_pc[rd_ptr]    : '0;
   assign inst_fault = inst_valid ? buf_fault[rd_ptr] : 1'b0;

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state;
      fetch_pc_d   = fetch_pc;
      araddr_d     = araddr;
      arvalid_d    = arvalid;
      rready_d     = rready;
      halted_d     = halted;
      flush_pend_d = flush_pend;
      push         = 1'b0;

      unique case (state)
         IDLE: begin
            if (!halted && (count < FULL_CNT) && !redirect_valid) begin
               state_d   = SEND_ADDR;
               araddr_d  = fetch_pc;
               arvalid_d = 1'b1;
            end
         end

         SEND_ADDR: begin
            // The address phase is never withdrawn; a redirect only marks
            // the request as stale.
            if (redirect_valid) begin
               flush_pend_d = 1'b1;
            end
            if (arready) begin
               arvalid_d    = 1'b0;
               rready_d     = 1'b1;
               flush_pend_d = 1'b0;
               if (flush_pend || redirect_valid) begin
                  state_d = DRAIN;
               end else begin
                  state_d    = WAIT_DATA;
                  fetch_pc_d = fetch_pc + PC_STEP;
               end
            end
         end

         WAIT_DATA: begin
            if (rvalid) begin
               // A response coinciding with a redirect is consumed here and
               // dropped; waiting in DRAIN would wait for a beat that is gone.
               rready_d = 1'b0;
               state_d  = IDLE;
               if (!redirect_valid) begin
                  push = 1'b1;
                  if (rresp != 2'b00) begin
                     halted_d = 1'b1;
                  end
               end
            end else if (redirect_valid) begin
               state_d = DRAIN;
            end
         end

         DRAIN: begin
            if (rvalid) begin
               rready_d = 1'b0;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
         halted_d   = 1'b0;
      end
   end

   // Control registers and buffer pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         araddr     <= '0;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         halted     <= 1'b0;
         flush_pend <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         state      <= state_d;
         fetch_pc   <= fetch_pc_d;
         araddr     <= araddr_d;
         arvalid    <= arvalid_d;
         rready     <= rready_d;
         halted     <= halted_d;
         flush_pend <= flush_pend_d;

         // A redirect wins over any push or pop in the same cycle.
         if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
               count <= count + CNT_W'(1);
            end else if (!push && pop) begin
               count <= count - CNT_W'(1);
            end
         end
      end
   end

   // Buffer storage; contents are only meaningful below count
   always_ff @(posedge clk) begin
      if (push) begin
         buf_inst[wr_ptr]  <= rdata;
         buf_pc[wr_ptr]    <= araddr;
         buf_fault[wr_ptr] <= (rresp != 2'b00);
      end
   end

endmodule

// File: tb/tb_ifu_prefetch_axil.sv
// ----------------------------------------------------------------------------
// Bench for ifu_prefetch_axil. A behavioural AXI-Lite slave answers reads
// with (address ^ key) and a fault response at one chosen address. The
// reference model is the expected instruction stream: consecutive word
// addresses starting at the reset PC or the last redirect target, ending
// after the faulting word until the next redirect.
// ----------------------------------------------------------------------------
module tb_ifu_prefetch_axil;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        idu_ready = 1'b0;
   logic [31:0] inst, inst_pc, araddr;
   logic        inst_fault, inst_valid, arvalid, rready;
   logic        arready = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic [1:0]  rresp = 2'b00;

   ifu_prefetch_axil dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault),
      .inst_valid     (inst_valid),
      .idu_ready      (idu_ready),
      .araddr         (araddr),
      .arvalid        (arvalid),
      .arready        (arready),
      .rdata          (rdata),
      .rresp          (rresp),
      .rvalid         (rvalid),
      .rready         (rready)
   );

   // Slave configuration
   logic        s_stall = 1'b0;
   logic        s_rand = 1'b0;
   int          s_rdelay = 0;
   logic [31:0] key = 32'h0;
   logic [31:0] fault_addr = 32'h1;

   // Slave state
   logic        s_pend = 1'b0;
   logic [31:0] s_addr = 32'h0;
   int          s_dly = 0;

   always begin : slave
      logic        ar_hs, r_hs;
      logic [31:0] a;
      @(negedge clk);
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      a     = araddr;
      @(posedge clk);
      #2;
      if (rst) begin
         arready = 1'b0;
         rvalid  = 1'b0;
         s_pend  = 1'b0;
      end else begin
         if (r_hs) rvalid = 1'b0;
         if (ar_hs) begin
            s_pend = 1'b1;
            s_addr = a;
            s_dly  = s_rand ? int'($urandom_range(0, 3)) : s_rdelay;
         end
         if (s_pend && !rvalid) begin
            if (s_dly == 0) begin
               rvalid = 1'b1;
               rdata  = s_addr ^ key;
               rresp  = (s_addr == fault_addr) ? 2'b10 : 2'b00;
               s_pend = 1'b0;
            end else begin
               s_dly = s_dly - 1;
            end
         end
         arready = !s_stall && (s_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Scoreboard state
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic        halted_exp = 1'b0;
   int          pops = 0;
   int          total_pops = 0;
   int          ar_hs_cnt = 0;
   int          outstanding = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic [31:0] first_pop_pc = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe mid-cycle, then advance past the rising edge.
   task automatic step();
      @(negedge clk);
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("ar_hold_valid", 32'(arvalid), 32'd1);
            chk("ar_hold_addr", araddr, prev_addr);
         end
         prev_stall = arvalid && !arready;
         prev_addr  = araddr;
         if (rvalid && rready) outstanding--;
         if (arvalid && arready) begin
            chk("one_outstanding", 32'(outstanding), 32'd0);
            outstanding++;
            ar_hs_cnt++;
         end
         if (halted_exp && !redirect_valid) begin
            chk("halt_empty", 32'(inst_valid), 32'd0);
            chk("halt_no_ar", 32'(arvalid), 32'd0);
         end else if (inst_valid && idu_ready && !redirect_valid) begin
            if (pops == 0) first_pop_pc = inst_pc;
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_inst", inst, exp_pc ^ key);
            chk("pop_fault", 32'(inst_fault), 32'(exp_pc == fault_addr));
            if (exp_pc == fault_addr) halted_exp = 1'b1;
            exp_pc = exp_pc + 32'd4;
            pops++;
            total_pops++;
         end
      end
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      idu_ready = 1'b0;
      repeat (3) step();
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_inst_fault", 32'(inst_fault), 32'd0);
      rst = 1'b0;
      exp_pc = RESET_PC;
      halted_exp = 1'b0;
      pops = 0;
      ar_hs_cnt = 0;
      outstanding = 0;
      prev_stall = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc = pc;
      step();
      redirect_valid = 1'b0;
      exp_pc = {pc[31:2], 2'b00};
      halted_exp = 1'b0;
      pops = 0;
      chk("flush_empty", 32'(inst_valid), 32'd0);
   endtask

   initial begin
      logic found;

      // Zero-wait slave, data equals address, decoder always ready
      do_reset();
      idu_ready = 1'b1;
      step();
      chk("first_arvalid", 32'(arvalid), 32'd1);
      chk("first_araddr", araddr, RESET_PC);
      repeat (29) step();
      chk("thru_lo", 32'(pops >= 8), 32'd1);
      chk("thru_hi", 32'(pops <= 10), 32'd1);

      // Decoder stalled: buffer fills with exactly DEPTH fetches
      do_reset();
      repeat (40) step();
      chk("fill_hs", 32'(ar_hs_cnt), 32'd4);
      chk("fill_arvalid", 32'(arvalid), 32'd0);
      chk("fill_valid", 32'(inst_valid), 32'd1);
      chk("fill_head", inst_pc, RESET_PC);
      idu_ready = 1'b1;
      repeat (20) step();
      chk("drain_pops", 32'(pops >= 4), 32'd1);
      chk("resume_fetch", 32'(ar_hs_cnt > 4), 32'd1);

      // Address channel stalled for several cycles
      s_stall = 1'b1;
      do_reset();
      idu_ready = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_arvalid", 32'(arvalid), 32'd1);
         chk("stall_araddr", araddr, RESET_PC);
      end
      chk("stall_no_hs", 32'(ar_hs_cnt), 32'd0);
      s_stall = 1'b0;
      repeat (2) step();
      chk("stall_one_hs", 32'(ar_hs_cnt), 32'd1);
      repeat (10) step();
      chk("stall_pops", 32'(pops >= 1), 32'd1);

      // Redirect while waiting for read data
      s_rdelay = 3;
      do_reset();
      idu_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (rready && !rvalid && ar_hs_cnt == 1) found = 1'b1;
      end
      chk("wait_found", 32'(found), 32'd1);
      redirect(32'h8000_1000);
      chk("drain_rready", 32'(rready), 32'd1);
      repeat (40) step();
      chk("redir_pops", 32'(pops >= 2), 32'd1);
      chk("redir_first_pc", first_pop_pc, 32'h8000_1000);
      s_rdelay = 0;

      // Fault on the third fetch
      fault_addr = 32'h8000_0008;
      do_reset();
      idu_ready = 1'b1;
      repeat (30) step();
      chk("fault_hs", 32'(ar_hs_cnt), 32'd3);
      chk("fault_halted", 32'(halted_exp), 32'd1);
      chk("fault_arvalid", 32'(arvalid), 32'd0);
      redirect(32'h8000_0101);
      repeat (15) step();
      chk("fault_restart", 32'(pops >= 3), 32'd1);
      chk("fault_restart_pc", first_pop_pc, 32'h8000_0100);
      fault_addr = 32'h1;

      // Redirect together with a pop and an arriving response
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step();
         if (ar_hs_cnt == 4 && rvalid && rready && inst_valid) found = 1'b1;
      end
      chk("full_found", 32'(found), 32'd1);
      idu_ready = 1'b1;
      redirect(32'h8000_2000);
      repeat (20) step();
      chk("full_restart", 32'(pops >= 3), 32'd1);

      // Fetch address wraps at the top of the address space
      do_reset();
      idu_ready = 1'b1;
      redirect(32'hFFFF_FFF8);
      repeat (20) step();
      chk("wrap_pops", 32'(pops >= 4), 32'd1);

      // Randomized slave timing, decoder readiness and redirects
      s_rand = 1'b1;
      key = $urandom;
      fault_addr = RESET_PC + 32'(4 * $urandom_range(4, 40));
      do_reset();
      total_pops = 0;
      for (int i = 0; i < 600; i++) begin
         idu_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0)
            redirect(RESET_PC + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3)));
         else
            step();
      end
      chk("rand_progress", 32'(total_pops > 30), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
